// File: rtl/dp_pkg.sv
// Shared definitions for the data-processing issue block: opcodes, FSM states,
// instruction field positions and condition codes.
package dp_pkg;

    localparam logic [4:0] OPC_ADD = 5'b00100;
    localparam logic [4:0] OPC_ADC = 5'b00101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_ILL    = 3'd4
    } state_e;

    localparam int COND_HI  = 31;
    localparam int COND_LO  = 28;
    localparam int CLASS_HI = 27;
    localparam int CLASS_LO = 26;
    localparam int I_BIT    = 25;
    localparam int OPC_HI   = 24;
    localparam int OPC_LO   = 21;
    localparam int S_BIT    = 20;
    localparam int RN_HI    = 19;
    localparam int RN_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 12;
    localparam int IMM_HI   = 11;
    localparam int IMM_LO   = 0;
    localparam int SH_HI    = 11;
    localparam int SH_LO    = 7;
    localparam int STY_HI   = 6;
    localparam int STY_LO   = 5;
    localparam int REG_BIT  = 4;
    localparam int RM_HI    = 3;
    localparam int RM_LO    = 0;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Returns {cond_known, cond_pass} for the current flag state.
    function automatic logic [1:0] cond_eval(input logic [3:0] cond, input logic n,
                                             input logic z, input logic c);
        logic [1:0] res;
        case (cond)
            COND_EQ: res = {1'b1, z};
            COND_NE: res = {1'b1, ~z};
            COND_CS: res = {1'b1, c};
            COND_CC: res = {1'b1, ~c};
            COND_MI: res = {1'b1, n};
            COND_PL: res = {1'b1, ~n};
            COND_AL: res = {1'b1, 1'b1};
            default: res = {1'b0, 1'b0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dp_decode.sv
// Combinational field extraction and legality check for one A32 data-processing word.
// Condition evaluation is compiled in only when DP_ISSUE_COND_EN is defined.
module dp_decode
    import dp_pkg::*;
(
    input  logic [31:0] word,
    input  logic        flag_n,
    input  logic        flag_z,
    input  logic        flag_c,
    output logic        imm_bit,
    output logic        s_bit,
    output logic [4:0]  instruction,
    output logic [3:0]  rn_addr,
    output logic [3:0]  rd_addr,
    output logic [3:0]  rm_addr,
    output logic [11:0] imm12,
    output logic [4:0]  shift5,
    output logic [1:0]  stype,
    output logic        legal,
    output logic        cond_pass
);

    logic supported_s;

    assign imm_bit     = word[I_BIT];
    assign s_bit       = word[S_BIT];
    assign instruction = {1'b0, word[OPC_HI:OPC_LO]};
    assign rn_addr     = word[RN_HI:RN_LO];
    assign rd_addr     = word[RD_HI:RD_LO];
    assign rm_addr     = word[RM_HI:RM_LO];
    assign imm12       = word[IMM_HI:IMM_LO];
    assign shift5      = word[SH_HI:SH_LO];
    assign stype       = word[STY_HI:STY_LO];

    // Register-form words with bit4 set are register-shifted forms, which are not handled.
    assign supported_s = (word[CLASS_HI:CLASS_LO] == 2'b00)
                       && ((instruction == OPC_ADD) || (instruction == OPC_ADC))
                       && (word[I_BIT] || !word[REG_BIT]);

`ifdef DP_ISSUE_COND_EN
    logic [1:0] cond_res_s;

    assign cond_res_s = cond_eval(word[COND_HI:COND_LO], flag_n, flag_z, flag_c);
    assign legal      = supported_s && cond_res_s[1];
    assign cond_pass  = cond_res_s[0];
`else
    logic unused_cond_s;

    assign unused_cond_s = ^{word[COND_HI:COND_LO], flag_n, flag_z, flag_c};
    assign legal         = supported_s;
    assign cond_pass     = 1'b1;
`endif

endmodule

// File: rtl/dp_issue.sv
// Issue FSM for ADD/ADC data-processing words: decode, drive the add unit for
// EXEC_LAT cycles, write back and update flags. DP_ISSUE_COND_EN enables cond checks.
module dp_issue
    import dp_pkg::*;
#(
    parameter int unsigned EXEC_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr_word,
    output logic        instr_ready,
    output logic [3:0]  rf_raddr_n,
    output logic [3:0]  rf_raddr_m,
    input  logic [31:0] rf_rdata_n,
    input  logic [31:0] rf_rdata_m,
    output logic        en_inst,
    output logic        IMM,
    output logic [4:0]  instruction,
    output logic        S,
    output logic [31:0] Rn,
    output logic [11:0] imm_operand,
    output logic [4:0]  imm_shift,
    output logic [1:0]  stype,
    output logic [31:0] Rm,
    output logic        carry_in,
    output logic        zero_in,
    output logic        neg_in,
    input  logic [31:0] Rd,
    input  logic        carry_out,
    input  logic        zero_out,
    input  logic        neg_out,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        flag_n,
    output logic        flag_z,
    output logic        flag_c,
    output logic        illegal
);

    localparam logic [3:0] LAT_M1 = 4'(EXEC_LAT - 1);

    state_e      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        instr_ready_q, instr_ready_d;
    logic        en_inst_q, en_inst_d;
    logic        imm_q, imm_d;
    logic [4:0]  instruction_q, instruction_d;
    logic        s_q, s_d;
    logic [31:0] rn_q, rn_d;
    logic [31:0] rm_q, rm_d;
    logic [11:0] imm_operand_q, imm_operand_d;
    logic [4:0]  imm_shift_q, imm_shift_d;
    logic [1:0]  stype_q, stype_d;
    logic        carry_in_q, carry_in_d;
    logic        zero_in_q, zero_in_d;
    logic        neg_in_q, neg_in_d;
    logic        rf_we_q, rf_we_d;
    logic [3:0]  rf_waddr_q, rf_waddr_d;
    logic        flag_n_q, flag_n_d;
    logic        flag_z_q, flag_z_d;
    logic        flag_c_q, flag_c_d;
    logic        illegal_q, illegal_d;

    logic        dec_imm_s, dec_s_s, dec_legal_s, dec_pass_s;
    logic [4:0]  dec_instruction_s, dec_shift_s;
    logic [3:0]  dec_rn_s, dec_rd_s, dec_rm_s;
    logic [11:0] dec_imm12_s;
    logic [1:0]  dec_stype_s;

    dp_decode u_decode (
        .word        (word_q),
        .flag_n      (flag_n_q),
        .flag_z      (flag_z_q),
        .flag_c      (flag_c_q),
        .imm_bit     (dec_imm_s),
        .s_bit       (dec_s_s),
        .instruction (dec_instruction_s),
        .rn_addr     (dec_rn_s),
        .rd_addr     (dec_rd_s),
        .rm_addr     (dec_rm_s),
        .imm12       (dec_imm12_s),
        .shift5      (dec_shift_s),
        .stype       (dec_stype_s),
        .legal       (dec_legal_s),
        .cond_pass   (dec_pass_s)
    );

    // Next-state, exec-bus capture, counter and flag update logic.
    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        cnt_d         = cnt_q;
        imm_d         = imm_q;
        instruction_d = instruction_q;
        s_d           = s_q;
        rn_d          = rn_q;
        rm_d          = rm_q;
        imm_operand_d = imm_operand_q;
        imm_shift_d   = imm_shift_q;
        stype_d       = stype_q;
        carry_in_d    = carry_in_q;
        zero_in_d     = zero_in_q;
        neg_in_d      = neg_in_q;
        rf_waddr_d    = rf_waddr_q;
        flag_n_d      = flag_n_q;
        flag_z_d      = flag_z_q;
        flag_c_d      = flag_c_q;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid && instr_ready_q) begin
                    word_d  = instr_word;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (!dec_legal_s) begin
                    state_d = ST_ILL;
                end else if (!dec_pass_s) begin
                    state_d = ST_IDLE;
                end else begin
                    // Operands are captured here, so a writeback to Rn/Rm cannot disturb them.
                    imm_d         = dec_imm_s;
                    instruction_d = dec_instruction_s;
                    s_d           = dec_s_s;
                    rn_d          = rf_rdata_n;
                    rm_d          = rf_rdata_m;
                    imm_operand_d = dec_imm12_s;
                    imm_shift_d   = dec_shift_s;
                    stype_d       = dec_stype_s;
                    carry_in_d    = flag_c_q;
                    zero_in_d     = flag_z_q;
                    neg_in_d      = flag_n_q;
                    rf_waddr_d    = dec_rd_s;
                    cnt_d         = LAT_M1;
                    state_d       = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_WB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
                if (s_q) begin
                    flag_n_d = neg_out;
                    flag_z_d = zero_out;
                    flag_c_d = carry_out;
                end else begin
                    flag_n_d = flag_n_q;
                end
            end
            ST_ILL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        instr_ready_d = (state_d == ST_IDLE);
        en_inst_d     = (state_d == ST_EXEC) || (state_d == ST_WB);
        rf_we_d       = (state_d == ST_WB);
        illegal_d     = (state_d == ST_ILL);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            word_q        <= 32'h0;
            cnt_q         <= 4'd0;
            instr_ready_q <= 1'b1;
            en_inst_q     <= 1'b0;
            imm_q         <= 1'b0;
            instruction_q <= 5'd0;
            s_q           <= 1'b0;
            rn_q          <= 32'h0;
            rm_q          <= 32'h0;
            imm_operand_q <= 12'h0;
            imm_shift_q   <= 5'd0;
            stype_q       <= 2'd0;
            carry_in_q    <= 1'b0;
            zero_in_q     <= 1'b0;
            neg_in_q      <= 1'b0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= 4'd0;
            flag_n_q      <= 1'b0;
            flag_z_q      <= 1'b0;
            flag_c_q      <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            cnt_q         <= cnt_d;
            instr_ready_q <= instr_ready_d;
            en_inst_q     <= en_inst_d;
            imm_q         <= imm_d;
            instruction_q <= instruction_d;
            s_q           <= s_d;
            rn_q          <= rn_d;
            rm_q          <= rm_d;
            imm_operand_q <= imm_operand_d;
            imm_shift_q   <= imm_shift_d;
            stype_q       <= stype_d;
            carry_in_q    <= carry_in_d;
            zero_in_q     <= zero_in_d;
            neg_in_q      <= neg_in_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            flag_n_q      <= flag_n_d;
            flag_z_q      <= flag_z_d;
            flag_c_q      <= flag_c_d;
            illegal_q     <= illegal_d;
        end
    end

    assign rf_raddr_n  = dec_rn_s;
    assign rf_raddr_m  = dec_rm_s;
    assign instr_ready = instr_ready_q;
    assign en_inst     = en_inst_q;
    assign IMM         = imm_q;
    assign instruction = instruction_q;
    assign S           = s_q;
    assign Rn          = rn_q;
    assign Rm          = rm_q;
    assign imm_operand = imm_operand_q;
    assign imm_shift   = imm_shift_q;
    assign stype       = stype_q;
    assign carry_in    = carry_in_q;
    assign zero_in     = zero_in_q;
    assign neg_in      = neg_in_q;
    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_we_q ? Rd : 32'h0;
    assign flag_n      = flag_n_q;
    assign flag_z      = flag_z_q;
    assign flag_c      = flag_c_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_dp_issue.sv
// Self-checking bench for dp_issue: directed and random words against an
// instruction-level reference model (register array + flags).
module tb_dp_issue;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr_word;
    logic        instr_ready;
    logic [3:0]  rf_raddr_n, rf_raddr_m;
    logic [31:0] rf_rdata_n, rf_rdata_m;
    logic        en_inst, IMM, S;
    logic [4:0]  instruction, imm_shift;
    logic [31:0] Rn, Rm;
    logic [11:0] imm_operand;
    logic [1:0]  stype;
    logic        carry_in, zero_in, neg_in;
    logic [31:0] Rd;
    logic        carry_out, zero_out, neg_out;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flag_n, flag_z, flag_c, illegal;

    int tests = 0;
    int fails = 0;

    dp_issue #(.EXEC_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_word(instr_word),
        .instr_ready(instr_ready), .rf_raddr_n(rf_raddr_n), .rf_raddr_m(rf_raddr_m),
        .rf_rdata_n(rf_rdata_n), .rf_rdata_m(rf_rdata_m), .en_inst(en_inst), .IMM(IMM),
        .instruction(instruction), .S(S), .Rn(Rn), .imm_operand(imm_operand),
        .imm_shift(imm_shift), .stype(stype), .Rm(Rm), .carry_in(carry_in),
        .zero_in(zero_in), .neg_in(neg_in), .Rd(Rd), .carry_out(carry_out),
        .zero_out(zero_out), .neg_out(neg_out), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Bench-owned register file, preloaded while rf_load is high.
    logic [31:0] rf [16];
    logic [31:0] rf_init [16];
    logic        rf_load;
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 16; i++) rf[i] <= rf_init[i];
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end
    assign rf_rdata_n = rf[rf_raddr_n];
    assign rf_rdata_m = rf[rf_raddr_m];

    // Stand-in add unit: Rn + (imm12 or Rm) + carry for ADC.
    logic [32:0] ex_sum;
    always_comb begin
        ex_sum    = {1'b0, Rn} + {1'b0, (IMM ? {20'h0, imm_operand} : Rm)}
                  + {32'h0, (instruction == 5'b00101) ? carry_in : 1'b0};
        Rd        = ex_sum[31:0];
        carry_out = ex_sum[32];
        zero_out  = (ex_sum[31:0] == 32'h0);
        neg_out   = ex_sum[31];
    end

    // Event monitors.
    int   cyc = 0, en_rise = 0, we_cnt = 0;
    logic en_prev = 1'b0;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        en_prev <= en_inst;
        if (en_inst && !en_prev) en_rise <= en_rise + 1;
        if (rf_we) we_cnt <= we_cnt + 1;
    end

    // Reference model state.
    logic [31:0] m_rf [16];
    logic        m_n = 1'b0, m_z = 1'b0, m_c = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 0 = executes, 1 = illegal, 2 = skipped on failed condition.
    function automatic int model_kind(input logic [31:0] w);
        logic ok;
        ok = (w[27:26] == 2'b00) && (w[24:21] == 4'd4 || w[24:21] == 4'd5) && (w[25] || !w[4]);
        if (!ok) return 1;
`ifdef DP_ISSUE_COND_EN
        case (w[31:28])
            4'h0: return m_z ? 0 : 2;
            4'h1: return m_z ? 2 : 0;
            4'h2: return m_c ? 0 : 2;
            4'h3: return m_c ? 2 : 0;
            4'h4: return m_n ? 0 : 2;
            4'h5: return m_n ? 2 : 0;
            4'hE: return 0;
            default: return 1;
        endcase
`else
        return 0;
`endif
    endfunction

    function automatic logic [32:0] model_sum(input logic [31:0] w);
        logic [31:0] op2;
        logic        cin;
        op2 = w[25] ? {20'h0, w[11:0]} : m_rf[w[3:0]];
        cin = (w[24:21] == 4'd5) ? m_c : 1'b0;
        return {1'b0, m_rf[w[19:16]]} + {1'b0, op2} + {32'h0, cin};
    endfunction

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!instr_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, ".ready_wait"}, {31'h0, instr_ready}, 32'h1);
    endtask

    task automatic model_commit(input logic [31:0] w);
        logic [32:0] sum;
        if (model_kind(w) == 0) begin
            sum = model_sum(w);
            m_rf[w[15:12]] = sum[31:0];
            if (w[20]) begin
                m_n = sum[31];
                m_z = (sum[31:0] == 32'h0);
                m_c = sum[32];
            end
        end
    endtask

    // Issues one word from IDLE and checks every cycle until the FSM returns to IDLE.
    task automatic issue(input logic [31:0] w, input string tag);
        int          kind, n, exp_n, en_c, we_c, ill_c;
        logic [32:0] sum;
        bit          done;
        kind  = model_kind(w);
        sum   = model_sum(w);
        exp_n = (kind == 0) ? 3 + LAT : (kind == 1) ? 3 : 2;
        en_c = 0; we_c = 0; ill_c = 0; n = 0; done = 1'b0;
        @(negedge clk);
        instr_word  = w;
        instr_valid = 1'b1;
        wait_ready(tag);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (instr_ready || n >= 30) begin
                done = 1'b1;
            end else begin
                en_c  += int'(en_inst);
                we_c  += int'(rf_we);
                ill_c += int'(illegal);
                if (en_inst && kind == 0) begin
                    check({tag, ".bus"}, {IMM, instruction, S, imm_operand, imm_shift, stype, 6'h0},
                          {w[25], 1'b0, w[24:21], w[20], w[11:0], w[11:7], w[6:5], 6'h0});
                    check({tag, ".Rn"}, Rn, m_rf[w[19:16]]);
                    check({tag, ".Rm"}, Rm, m_rf[w[3:0]]);
                    check({tag, ".flags_in"}, {29'h0, neg_in, zero_in, carry_in}, {29'h0, m_n, m_z, m_c});
                end
                if (rf_we) begin
                    check({tag, ".waddr"}, {28'h0, rf_waddr}, {28'h0, w[15:12]});
                    check({tag, ".wdata"}, rf_wdata, sum[31:0]);
                end
            end
        end
        check({tag, ".idle_at"}, n, exp_n);
        check({tag, ".en_cycles"}, en_c, (kind == 0) ? LAT + 1 : 0);
        check({tag, ".we_cycles"}, we_c, (kind == 0) ? 1 : 0);
        check({tag, ".ill_cycles"}, ill_c, (kind == 1) ? 1 : 0);
        check({tag, ".en_idle"}, {31'h0, en_inst}, 32'h0);
        model_commit(w);
        check({tag, ".flags"}, {29'h0, flag_n, flag_z, flag_c}, {29'h0, m_n, m_z, m_c});
        check({tag, ".rf"}, rf[w[15:12]], m_rf[w[15:12]]);
    endtask

    initial begin
        logic [31:0] w;
        int          acc0, acc1, er0, we0, k;
        instr_valid = 1'b0;
        instr_word  = 32'h0;
        rst         = 1'b1;
        rf_load     = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rf_init[i] = $urandom;
        end
        rf_init[1] = 32'h0000_0010;
        rf_init[3] = 32'hFFFF_FFFF;
        rf_init[5] = 32'h0000_0000;
        for (int i = 0; i < 16; i++) m_rf[i] = rf_init[i];
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.ctrl", {28'h0, instr_ready, en_inst, rf_we, illegal}, {28'h0, 4'b1000});
        check("reset.flags", {29'h0, flag_n, flag_z, flag_c}, 32'h0);
        check("reset.bus", {IMM, instruction, S, imm_operand, imm_shift, stype, carry_in, zero_in, neg_in},
              32'h0);
        check("reset.ops", Rn | Rm, 32'h0);
        rst     = 1'b0;
        rf_load = 1'b0;

        // ADD imm, flags untouched; ADDS to set C, then ADCS register form.
        issue(32'hE281_2005, "add_imm");
        issue(32'hE293_6001, "adds_carry");
        check("adcs.pre_c", {31'h0, flag_c}, 32'h1);
        issue(32'hE0B3_4005, "adcs_reg");
        check("adcs.nzc", {29'h0, flag_n, flag_z, flag_c}, {29'h0, 3'b011});
        issue(32'hE041_2003, "sub_illegal");
        issue(32'hE081_2013, "reg_shift_illegal");
        issue(32'hE681_2005, "class_illegal");

        // Back-to-back with instr_valid held.
        er0 = en_rise; we0 = we_cnt;
        @(negedge clk);
        instr_word  = 32'hE281_7003;
        instr_valid = 1'b1;
        wait_ready("b2b0");
        acc0 = cyc;
        @(negedge clk);
        instr_word = 32'hE087_8001;
        @(negedge clk);
        wait_ready("b2b1");
        acc1 = cyc;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        wait_ready("b2b_end");
        @(negedge clk);
        check("b2b.spacing", acc1 - acc0, 3 + LAT);
        check("b2b.en_rises", en_rise - er0, 2);
        check("b2b.we_pulses", we_cnt - we0, 2);
        model_commit(32'hE281_7003);
        model_commit(32'hE087_8001);
        check("b2b.r7", rf[7], m_rf[7]);
        check("b2b.r8", rf[8], m_rf[8]);

        // Random words, mostly legal.
        for (int t = 0; t < 30; t++) begin
            w = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                w[27:26] = 2'b00;
                w[24:21] = 4'd4 + 4'($urandom_range(0, 1));
                if (!w[25]) w[4] = 1'b0;
`ifdef DP_ISSUE_COND_EN
                if ($urandom_range(0, 1) == 0) w[31:28] = 4'hE;
                else w[31:28] = 4'($urandom_range(0, 5));
`endif
            end
            issue(w, $sformatf("rnd%0d", t));
        end

`ifdef DP_ISSUE_COND_EN
        issue(32'hE290_9000, "cond_setz");
        issue(32'h0281_2001, "cond_eq_z1");
        issue(32'hE291_9001, "cond_clrz");
        issue(32'h0281_2005, "cond_eq_z0");
        issue(32'h7281_2005, "cond_unknown");
`endif

        // Reset in the second EXEC cycle aborts the instruction.
        issue(32'hE293_6001, "pre_abort");
        we0 = we_cnt;
        @(negedge clk);
        instr_word  = 32'hE0B3_4005;
        instr_valid = 1'b1;
        wait_ready("abort");
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort.in_exec", {31'h0, en_inst}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_n = 1'b0; m_z = 1'b0; m_c = 1'b0;
        check("abort.ctrl", {29'h0, instr_ready, en_inst, rf_we}, {29'h0, 3'b100});
        check("abort.flags", {29'h0, flag_n, flag_z, flag_c}, 32'h0);
        for (k = 0; k < 6; k++) @(negedge clk);
        check("abort.no_we", we_cnt - we0, 0);
        check("abort.r4", rf[4], m_rf[4]);
        issue(32'hE281_2005, "post_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
